// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port round-robin arbiter with bounded burst lock in front
//                of a single-port data memory. One access per cycle; range
//                checks addresses against the implemented memory depth.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 64,
  parameter int LOCK_MAX  = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic              p0_lock,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,

  input  logic              p1_req,
  input  logic              p1_lock,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Lock counter must be able to hold LOCK_MAX itself.
  localparam int                 c_cnt_w    = $clog2(LOCK_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_lock_max = c_cnt_w'(LOCK_MAX);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  // One extra bit so a depth of exactly 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]    c_depth    = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rr_ptr;
  logic [c_cnt_w-1:0]  r_lock_cnt;
  logic [c_cnt_w-1:0]  w_lock_cnt_nxt;
  logic [c_cnt_w-1:0]  w_cnt_grant;

  logic                w_win_valid;
  logic                w_win_sel;
  logic                w_win_cont;
  logic                w_win_we;
  logic                w_win_lock;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;
  logic                w_in_range;

  logic                r_p0_done;
  logic [DATA_W-1:0]   r_p0_rdata;
  logic                r_p0_err;
  logic                r_p1_done;
  logic [DATA_W-1:0]   r_p1_rdata;
  logic                r_p1_err;

  // Winner selection: a requesting lock owner beats everything, then a lone
  // requester, then the round-robin pointer breaks ties.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_sel   = 1'b0;
    if (r_state == OWN0 && p0_req) begin
      w_win_valid = 1'b1;
      w_win_sel   = 1'b0;
    end else if (r_state == OWN1 && p1_req) begin
      w_win_valid = 1'b1;
      w_win_sel   = 1'b1;
    end else if (p0_req && p1_req) begin
      w_win_valid = 1'b1;
      w_win_sel   = r_rr_ptr;
    end else if (p0_req) begin
      w_win_valid = 1'b1;
      w_win_sel   = 1'b0;
    end else if (p1_req) begin
      w_win_valid = 1'b1;
      w_win_sel   = 1'b1;
    end
  end

  // Route the winner's request fields onto a common set of wires.
  always_comb begin
    w_win_we    = w_win_sel ? p1_we    : p0_we;
    w_win_lock  = w_win_sel ? p1_lock  : p0_lock;
    w_win_addr  = w_win_sel ? p1_addr  : p0_addr;
    w_win_wdata = w_win_sel ? p1_wdata : p0_wdata;
    w_in_range  = ({1'b0, w_win_addr} < c_depth);
    // Grant continues an existing ownership only if the owner itself wins.
    w_win_cont  = w_win_valid &&
                  ((!w_win_sel && r_state == OWN0) ||
                   ( w_win_sel && r_state == OWN1));
  end

  // Grants and memory-side drive; everything is zero when nobody wins and an
  // out-of-range write is suppressed so it cannot alias into the array.
  always_comb begin
    p0_gnt    = w_win_valid && !w_win_sel;
    p1_gnt    = w_win_valid &&  w_win_sel;
    mem_addr  = w_win_valid ? w_win_addr  : '0;
    mem_wdata = w_win_valid ? w_win_wdata : '0;
    mem_write = w_win_valid && w_win_we && w_in_range;
  end

  // Lock next-state: a grant with lock asserted enters/extends ownership
  // until the grant count reaches LOCK_MAX; every other case falls to IDLE.
  always_comb begin
    w_state_nxt    = IDLE;
    w_lock_cnt_nxt = '0;
    w_cnt_grant    = w_win_cont ? (r_lock_cnt + c_cnt_one) : c_cnt_one;
    if (w_win_valid && w_win_lock && (w_cnt_grant < c_lock_max)) begin
      w_state_nxt    = w_win_sel ? OWN1 : OWN0;
      w_lock_cnt_nxt = w_cnt_grant;
    end
  end

  // Lock FSM state, burst counter and fairness pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
      r_rr_ptr   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      if (w_win_valid) begin
        r_rr_ptr <= ~w_win_sel;
      end
    end
  end

  // Port 0 completion: one-cycle done pulse; rdata/err hold until next done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0_done  <= 1'b0;
      r_p0_rdata <= '0;
      r_p0_err   <= 1'b0;
    end else begin
      r_p0_done <= p0_gnt;
      if (p0_gnt) begin
        r_p0_err   <= !w_in_range;
        r_p0_rdata <= (!w_win_we && w_in_range) ? mem_rdata : '0;
      end
    end
  end

  // Port 1 completion: one-cycle done pulse; rdata/err hold until next done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_done  <= 1'b0;
      r_p1_rdata <= '0;
      r_p1_err   <= 1'b0;
    end else begin
      r_p1_done <= p1_gnt;
      if (p1_gnt) begin
        r_p1_err   <= !w_in_range;
        r_p1_rdata <= (!w_win_we && w_in_range) ? mem_rdata : '0;
      end
    end
  end

  assign p0_done  = r_p0_done;
  assign p0_rdata = r_p0_rdata;
  assign p0_err   = r_p0_err;
  assign p1_done  = r_p1_done;
  assign p1_rdata = r_p1_rdata;
  assign p1_err   = r_p1_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a
//                behavioural 64x8 memory and a completion scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic       clk;
  logic       rst;
  logic       p0_req, p0_lock, p0_we;
  logic [7:0] p0_addr, p0_wdata;
  logic       p0_gnt, p0_done, p0_err;
  logic [7:0] p0_rdata;
  logic       p1_req, p1_lock, p1_we;
  logic [7:0] p1_addr, p1_wdata;
  logic       p1_gnt, p1_done, p1_err;
  logic [7:0] p1_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_write;

  int checks;
  int failures;

  typedef struct {
    int         port;
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem[64];
  logic [7:0] ref_mem[64];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, synchronous write.
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic req, input logic lock, input logic we,
                        input logic [7:0] addr, input logic [7:0] wdata);
    p0_req = req; p0_lock = lock; p0_we = we; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic lock, input logic we,
                        input logic [7:0] addr, input logic [7:0] wdata);
    p1_req = req; p1_lock = lock; p1_we = we; p1_addr = addr; p1_wdata = wdata;
  endtask

  // One arbitration cycle: check grant and memory drive mid-cycle, queue the
  // expected completion, then check the done outputs just after the edge.
  task automatic step(input string tag, input logic eg0, input logic eg1, input logic emw);
    exp_t       e;
    exp_t       got;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wd;
    @(negedge clk);
    check({tag, ".gnt0"}, 32'(p0_gnt), 32'(eg0));
    check({tag, ".gnt1"}, 32'(p1_gnt), 32'(eg1));
    check({tag, ".mem_write"}, 32'(mem_write), 32'(emw));
    if (eg0 || eg1) begin
      we   = eg1 ? p1_we    : p0_we;
      addr = eg1 ? p1_addr  : p0_addr;
      wd   = eg1 ? p1_wdata : p0_wdata;
      check({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
      if (we) check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(wd));
      e.port  = eg1 ? 1 : 0;
      e.err   = (addr >= 8'd64);
      e.rdata = (!we && addr < 8'd64) ? ref_mem[addr[5:0]] : 8'h00;
      if (we && addr < 8'd64) ref_mem[addr[5:0]] = wd;
      sb.push_back(e);
    end else begin
      check({tag, ".mem_addr_idle"}, 32'(mem_addr), 32'h0);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check({tag, ".done0"}, 32'(p0_done), 32'(got.port == 0));
      check({tag, ".done1"}, 32'(p1_done), 32'(got.port == 1));
      if (got.port == 0) begin
        check({tag, ".rdata0"}, 32'(p0_rdata), 32'(got.rdata));
        check({tag, ".err0"}, 32'(p0_err), 32'(got.err));
      end else begin
        check({tag, ".rdata1"}, 32'(p1_rdata), 32'(got.rdata));
        check({tag, ".err1"}, 32'(p1_err), 32'(got.err));
      end
    end else begin
      check({tag, ".done0_idle"}, 32'(p0_done), 32'h0);
      check({tag, ".done1_idle"}, 32'(p1_done), 32'h0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst = 1'b1;
    drive0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset state
    #1;
    check("rst.gnt0", 32'(p0_gnt), 32'h0);
    check("rst.gnt1", 32'(p1_gnt), 32'h0);
    check("rst.mem_write", 32'(mem_write), 32'h0);
    check("rst.mem_addr", 32'(mem_addr), 32'h0);
    check("rst.done0", 32'(p0_done), 32'h0);
    check("rst.done1", 32'(p1_done), 32'h0);
    check("rst.rdata0", 32'(p0_rdata), 32'h0);
    check("rst.err1", 32'(p1_err), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Write then read back through port 0
    drive0(1'b1, 1'b0, 1'b1, 8'd5, 8'hA5);
    step("wr5", 1'b1, 1'b0, 1'b1);
    drive0(1'b1, 1'b0, 1'b0, 8'd5, 8'h00);
    step("rd5", 1'b1, 1'b0, 1'b0);
    drive0(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    step("idle", 1'b0, 1'b0, 1'b0);

    // Port 1 write leaves the pointer on port 0, then alternating reads
    drive1(1'b1, 1'b0, 1'b1, 8'd2, 8'h22);
    step("p1wr2", 1'b0, 1'b1, 1'b1);
    drive0(1'b1, 1'b0, 1'b0, 8'd5, 8'h00);
    drive1(1'b1, 1'b0, 1'b0, 8'd2, 8'h00);
    step("rr_a", 1'b1, 1'b0, 1'b0);
    step("rr_b", 1'b0, 1'b1, 1'b0);
    step("rr_c", 1'b1, 1'b0, 1'b0);
    step("rr_d", 1'b0, 1'b1, 1'b0);

    // Port 1 lock burst bounded at 8 grants while port 0 waits
    drive0(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    drive1(1'b1, 1'b1, 1'b0, 8'd2, 8'h00);
    step("lock1", 1'b0, 1'b1, 1'b0);
    drive0(1'b1, 1'b0, 1'b0, 8'd5, 8'h00);
    for (int i = 0; i < 7; i++) step("lock_hold", 1'b0, 1'b1, 1'b0);
    step("lock_release", 1'b1, 1'b0, 1'b0);
    step("relock", 1'b0, 1'b1, 1'b0);

    // Reset while port 1 owns the memory and is being granted
    @(negedge clk);
    check("own.gnt1", 32'(p1_gnt), 32'h1);
    check("own.gnt0", 32'(p0_gnt), 32'h0);
    rst = 1'b1;
    #1;
    check("midrst.done1", 32'(p1_done), 32'h0);
    check("midrst.done0", 32'(p0_done), 32'h0);
    check("midrst.rdata1", 32'(p1_rdata), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("postrst.done1", 32'(p1_done), 32'h0);
    check("postrst.done0", 32'(p0_done), 32'h0);
    drive1(1'b1, 1'b0, 1'b0, 8'd2, 8'h00);
    step("postrst_p0wins", 1'b1, 1'b0, 1'b0);

    // Out-of-range accesses
    drive1(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    drive0(1'b1, 1'b0, 1'b1, 8'd6, 8'h66);
    step("wr6", 1'b1, 1'b0, 1'b1);
    drive0(1'b1, 1'b0, 1'b1, 8'd70, 8'h3C);
    step("wr70_oor", 1'b1, 1'b0, 1'b0);
    drive0(1'b1, 1'b0, 1'b0, 8'd6, 8'h00);
    step("rd6", 1'b1, 1'b0, 1'b0);
    drive0(1'b1, 1'b0, 1'b0, 8'd200, 8'h00);
    step("rd200_oor", 1'b1, 1'b0, 1'b0);
    drive0(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    drive1(1'b1, 1'b0, 1'b0, 8'd6, 8'h00);
    step("p1rd6", 1'b0, 1'b1, 1'b0);

    // Same-cycle write (port 0) and read (port 1) of address 10
    drive0(1'b1, 1'b0, 1'b1, 8'd10, 8'h11);
    drive1(1'b1, 1'b0, 1'b0, 8'd10, 8'h00);
    step("conf_wr", 1'b1, 1'b0, 1'b1);
    drive0(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    step("conf_rd", 1'b0, 1'b1, 1'b0);
    drive1(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    step("drain", 1'b0, 1'b0, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
